iq_buf_axil_responder: RTL

AXI4-Lite slave (responder) that exposes a captured IQ sample buffer to the PS for polling. The block captures 16-bit I/Q pairs from the receive datapath into an internal RAM FIFO while armed. The CPU reads status and pops samples over AXI4-Lite. It sits behind the PS GP master port, on the same interconnect as the existing polling register block.

---
 rtl/iq_buf_axil_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/iq_buf_axil_responder.sv
// iq_buf_axil_responder
// AXI4-Lite responder that exposes a captured IQ sample buffer for polling.
// While armed, {i_data, q_data} pairs are pushed into an internal RAM FIFO.
// The CPU reads STATUS and pops samples from DATA.
//
// Register map (addr[3:2]):
//   0x00 CTRL    bit0 ARM (RW), bit1 CLEAR (write-1 pulse, reads 0)
//   0x04 STATUS  bit0 EMPTY, bit1 FULL, bit2 OVERFLOW (sticky), [31:16] COUNT
//   0x08 SCRATCH RW
//   0x0C DATA    RO, each read pops one sample (I in [31:16], Q in [15:0])
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   iq_valid, i_data, q_data          sample capture input
//   irq_full                          level, ARM && FULL, registered
//
// Read FSM:
//   state   | meaning
//   R_IDLE  | ARREADY follows ARVALID; address latched, DATA pop on handshake
//   R_FETCH | RAM output / latched register value moved into RDATA
//   R_VALID | RVALID high, RDATA held until RREADY

module iq_buf_axil_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DEPTH_LOG2         = 10
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              iq_valid,
    input  logic [15:0]                       i_data,
    input  logic [15:0]                       q_data,
    output logic                              irq_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PADW  = 16 - CW;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} rd_state_t;

    // Reset asserts asynchronously, releases two clocks after ARESETN rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_rst_sync <= 2'b00;
        else                r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic                          r_awready, r_bvalid, r_arm, r_ovf, r_irq;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_scratch;
    logic [DEPTH_LOG2-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]                 r_count;
    logic [31:0]                   r_mem [0:DEPTH-1];
    logic [31:0]                   r_ram_q;
    rd_state_t                     r_rstate, w_rstate_nxt;
    logic                          w_arready, w_rvalid;
    logic                          r_rsel_data, r_pop_ok;
    logic [31:0]                   r_rhold, r_rdata;

    logic w_wr_hs, w_ctrl_wr, w_scr_wr, w_clear;
    logic w_empty, w_full, w_pop, w_push_req, w_push, w_drop;
    logic [31:0] w_status;
    logic w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // ---------------- write channel ----------------
    // AWREADY/WREADY only ever rise together, and only with both valids present.
    assign w_wr_hs   = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_ctrl_wr = w_wr_hs && (S_AXI_AWADDR[3:2] == 2'd0);
    assign w_scr_wr  = w_wr_hs && (S_AXI_AWADDR[3:2] == 2'd2);
    assign w_clear   = w_ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arm     <= 1'b0;
            r_scratch <= '0;
        end else begin
            r_awready <= !r_awready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            if (w_wr_hs)
                r_bvalid <= 1'b1;
            else if (S_AXI_BREADY)
                r_bvalid <= 1'b0;
            if (w_ctrl_wr && S_AXI_WSTRB[0])
                r_arm <= S_AXI_WDATA[0];
            if (w_scr_wr) begin
                for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
                    if (S_AXI_WSTRB[b]) r_scratch[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- sample FIFO ----------------
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_arready && (S_AXI_ARADDR[3:2] == 2'd3) && !w_empty;
    assign w_push_req = r_arm && iq_valid;
    // A simultaneous pop frees the slot, so a full buffer still accepts the push.
    assign w_push     = w_push_req && (!w_full || w_pop) && !w_clear;
    assign w_drop     = w_push_req && w_full && !w_pop && !w_clear;

    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_arm && w_full;
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_drop) r_ovf <= 1'b1;
            end
        end
    end

    // Synchronous-read RAM; on a same-address push/pop the old word is read.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_data, q_data};
        r_ram_q <= r_mem[r_rd_ptr];
    end

    assign w_status = {{PADW{1'b0}}, r_count, 13'd0, r_ovf, w_full, w_empty};

    // ---------------- read channel ----------------
    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = S_AXI_ARVALID && w_rst_n;
                if (w_arready) w_rstate_nxt = R_FETCH;
            end
            R_FETCH: w_rstate_nxt = R_VALID;
            R_VALID: begin
                w_rvalid = 1'b1;
                if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rsel_data <= 1'b0;
            r_pop_ok    <= 1'b0;
            r_rhold     <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_arready) begin
                r_rsel_data <= (S_AXI_ARADDR[3:2] == 2'd3);
                r_pop_ok    <= w_pop;
                case (S_AXI_ARADDR[3:2])
                    2'd0:    r_rhold <= {31'd0, r_arm};
                    2'd1:    r_rhold <= w_status;
                    2'd2:    r_rhold <= r_scratch;
                    default: r_rhold <= '0;
                endcase
            end
            // An empty DATA read returns zero rather than stale RAM contents.
            if (r_rstate == R_FETCH)
                r_rdata <= r_rsel_data ? (r_pop_ok ? r_ram_q : 32'd0) : r_rhold;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign irq_full      = r_irq;

endmodule
